// File: rtl/uart_tx_fsm.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to compile in the parity bit; each bit is held OVERSAMPLE Bclk cycles.
module uart_tx_fsm #(
  parameter int OVERSAMPLE = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic       Bclk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data_in,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  // state    | meaning
  // S_IDLE   | line high, waiting for tx_start
  // S_START  | start bit (low)
  // S_DATA   | 8 data bits, LSB first
  // S_PARITY | even parity bit (parity build only)
  // S_STOP   | STOP_BITS high bit periods
  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] LAST_SAMPLE = CW'(OVERSAMPLE - 1);
  localparam logic [2:0]    LAST_STOP   = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
  } state_t;
`endif

  state_t          r_state, w_state;
  logic [CW-1:0]   r_sample_cnt, w_sample_cnt;
  logic [2:0]      r_bit_cnt, w_bit_cnt;
  logic [7:0]      r_shift, w_shift;
  logic            r_tx, w_tx;
  logic            r_busy, w_busy;
  logic            r_done, w_done;
  logic            w_bit_end;
`ifdef UART_TX_PARITY_EN
  logic            r_parity, w_parity;
`endif

  assign w_bit_end = (r_sample_cnt == LAST_SAMPLE);

  always_comb begin
    w_state      = r_state;
    w_sample_cnt = w_bit_end ? '0 : r_sample_cnt + 1'b1;
    w_bit_cnt    = r_bit_cnt;
    w_shift      = r_shift;
    w_tx         = r_tx;
    w_busy       = r_busy;
    w_done       = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_parity     = r_parity;
`endif
    case (r_state)
      S_IDLE: begin
        w_tx         = 1'b1;
        w_busy       = 1'b0;
        w_sample_cnt = '0;
        w_bit_cnt    = 3'd0;
        if (tx_start) begin
          w_state  = S_START;
          w_shift  = tx_data_in;
          w_tx     = 1'b0;
          w_busy   = 1'b1;
`ifdef UART_TX_PARITY_EN
          w_parity = ^tx_data_in;
`endif
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state   = S_DATA;
          w_tx      = r_shift[0];
          w_bit_cnt = 3'd0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == 3'd7) begin
            w_bit_cnt = 3'd0;
`ifdef UART_TX_PARITY_EN
            w_state   = S_PARITY;
            w_tx      = r_parity;
`else
            w_state   = S_STOP;
            w_tx      = 1'b1;
`endif
          end else begin
            w_shift   = {1'b0, r_shift[7:1]};
            w_tx      = r_shift[1];
            w_bit_cnt = r_bit_cnt + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_state   = S_STOP;
          w_tx      = 1'b1;
          w_bit_cnt = 3'd0;
        end
      end
`endif
      S_STOP: begin
        w_tx = 1'b1;
        if (w_bit_end) begin
          if (r_bit_cnt == LAST_STOP) begin
            w_state   = S_IDLE;
            w_busy    = 1'b0;
            w_done    = 1'b1;
            w_bit_cnt = 3'd0;
          end else begin
            w_bit_cnt = r_bit_cnt + 3'd1;
          end
        end
      end
      default: begin
        // unreachable encodings recover to an idle-high line
        w_state      = S_IDLE;
        w_tx         = 1'b1;
        w_busy       = 1'b0;
        w_sample_cnt = '0;
        w_bit_cnt    = 3'd0;
      end
    endcase
  end

  always_ff @(posedge Bclk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_sample_cnt <= '0;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'd0;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else begin
      r_state      <= w_state;
      r_sample_cnt <= w_sample_cnt;
      r_bit_cnt    <= w_bit_cnt;
      r_shift      <= w_shift;
      r_tx         <= w_tx;
      r_busy       <= w_busy;
      r_done       <= w_done;
`ifdef UART_TX_PARITY_EN
      r_parity     <= w_parity;
`endif
    end
  end

  assign tx      = r_tx;
  assign tx_busy = r_busy;
  assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Self-checking bench for uart_tx_fsm: frame waveforms compared cycle by cycle against a bit-list model.
module tb_uart_tx_fsm;
  localparam int OS = 8;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       Bclk = 1'b0;
  logic       reset;
  logic       tx_start, tx_start2;
  logic [7:0] tx_data_in, tx_data_in2;
  logic       tx, tx_busy, tx_done;
  logic       tx2, tx_busy2, tx_done2;

  int total = 0;
  int bad   = 0;

  always #5 Bclk = ~Bclk;

  uart_tx_fsm #(.OVERSAMPLE(OS), .STOP_BITS(1)) dut (
    .Bclk(Bclk), .reset(reset), .tx_start(tx_start), .tx_data_in(tx_data_in),
    .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  uart_tx_fsm #(.OVERSAMPLE(OS), .STOP_BITS(2)) dut2 (
    .Bclk(Bclk), .reset(reset), .tx_start(tx_start2), .tx_data_in(tx_data_in2),
    .tx(tx2), .tx_busy(tx_busy2), .tx_done(tx_done2)
  );

  // frame as a list of bits: start, d[0..7], optional parity, then stop bits
  function automatic logic model_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (P == 1 && idx == 9) return ^d;
    return 1'b1;
  endfunction

  function automatic int frame_cycles(input int sb);
    return (9 + P + sb) * OS;
  endfunction

  task automatic test_reset();
    reset = 1'b1; tx_start = 1'b0; tx_data_in = 8'h00; tx_start2 = 1'b0; tx_data_in2 = 8'h00;
    @(negedge Bclk);
    total++; if (tx !== 1'b1)      begin bad++; $display("FAIL reset_tx got=%b exp=1", tx); end
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
    total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", tx_done); end
    total++; if (tx2 !== 1'b1)     begin bad++; $display("FAIL reset_tx2 got=%b exp=1", tx2); end
    reset = 1'b0;
    @(negedge Bclk);
    tx_data_in = 8'h00; tx_start = 1'b1;
    @(negedge Bclk);
    tx_start = 1'b0;
    repeat (3) @(negedge Bclk);
    total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL async_pre_busy got=%b exp=1", tx_busy); end
    total++; if (tx !== 1'b0)      begin bad++; $display("FAIL async_pre_tx got=%b exp=0", tx); end
    @(posedge Bclk); #2;
    reset = 1'b1;
    #1;
    total++; if (tx !== 1'b1)      begin bad++; $display("FAIL async_reset_tx got=%b exp=1", tx); end
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL async_reset_busy got=%b exp=0", tx_busy); end
    total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL async_reset_done got=%b exp=0", tx_done); end
    @(negedge Bclk);
    reset = 1'b0;
    repeat (2) @(negedge Bclk);
  endtask

  task automatic test_single_frame();
    logic [7:0] d;
    logic exp_tx;
    int L, busy_cnt, done_cnt, done_at;
    d = 8'hA5; L = frame_cycles(1); busy_cnt = 0; done_cnt = 0; done_at = -1;
    tx_data_in = d; tx_start = 1'b1;
    @(negedge Bclk);
    tx_start = 1'b0; tx_data_in = 8'($urandom);
    for (int k = 0; k < L + 4; k++) begin
      exp_tx = (k < L) ? model_bit(d, k / OS) : 1'b1;
      total++;
      if (tx !== exp_tx) begin bad++; $display("FAIL single_tx k=%0d got=%b exp=%b", k, tx, exp_tx); end
      if (tx_busy === 1'b1) busy_cnt++;
      if (tx_done === 1'b1) begin done_cnt++; done_at = k; end
      @(negedge Bclk);
    end
    total++; if (busy_cnt != L) begin bad++; $display("FAIL single_busy_len got=%0d exp=%0d", busy_cnt, L); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL single_done_cnt got=%0d exp=1", done_cnt); end
    total++; if (done_at != L)  begin bad++; $display("FAIL single_done_at got=%0d exp=%0d", done_at, L); end
  endtask

  task automatic test_random_frames();
    logic [7:0] d;
    logic exp_tx, exp_busy, exp_done;
    int L;
    L = frame_cycles(1);
    for (int f = 0; f < 6; f++) begin
      d = 8'($urandom);
      repeat ($urandom_range(0, 4)) @(negedge Bclk);
      tx_data_in = d; tx_start = 1'b1;
      @(negedge Bclk);
      tx_start = 1'b0;
      for (int k = 0; k < L + 2; k++) begin
        tx_data_in = 8'($urandom);
        exp_tx   = (k < L) ? model_bit(d, k / OS) : 1'b1;
        exp_busy = (k < L);
        exp_done = (k == L);
        total++;
        if (tx !== exp_tx || tx_busy !== exp_busy || tx_done !== exp_done) begin
          bad++;
          $display("FAIL random d=%h k=%0d got tx/busy/done=%b%b%b exp=%b%b%b",
                   d, k, tx, tx_busy, tx_done, exp_tx, exp_busy, exp_done);
        end
        @(negedge Bclk);
      end
    end
  endtask

  task automatic test_ignored_request();
    logic [7:0] d;
    logic exp_tx;
    int L, done_cnt;
    d = 8'h81; L = frame_cycles(1); done_cnt = 0;
    tx_data_in = d; tx_start = 1'b1;
    @(negedge Bclk);
    tx_start = 1'b0;
    for (int k = 0; k < L + 3 * OS; k++) begin
      exp_tx = (k < L) ? model_bit(d, k / OS) : 1'b1;
      total++;
      if (tx !== exp_tx) begin bad++; $display("FAIL ignored_tx k=%0d got=%b exp=%b", k, tx, exp_tx); end
      if (tx_done === 1'b1) done_cnt++;
      if (k == 4 * OS + 2) begin tx_start = 1'b1; tx_data_in = 8'h3C; end
      else tx_start = 1'b0;
      @(negedge Bclk);
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL ignored_done_cnt got=%0d exp=1", done_cnt); end
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL ignored_second_frame busy=%b exp=0", tx_busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d0, d1;
    logic exp_tx, exp_busy;
    int L, first_done, second_done, done_cnt;
    d0 = 8'h00; d1 = 8'hFF; L = frame_cycles(1);
    first_done = -1; second_done = -1; done_cnt = 0;
    tx_data_in = d0; tx_start = 1'b1;
    @(negedge Bclk);
    tx_start = 1'b0;
    for (int k = 0; k < 2 * L + 4; k++) begin
      if (k < L)       exp_tx = model_bit(d0, k / OS);
      else if (k == L) exp_tx = 1'b1;
      else if (k <= 2 * L) exp_tx = model_bit(d1, (k - L - 1) / OS);
      else exp_tx = 1'b1;
      exp_busy = (k != L) && (k <= 2 * L);
      total++;
      if (tx !== exp_tx || tx_busy !== exp_busy) begin
        bad++;
        $display("FAIL b2b k=%0d got tx/busy=%b%b exp=%b%b", k, tx, tx_busy, exp_tx, exp_busy);
      end
      if (tx_done === 1'b1) begin
        done_cnt++;
        if (first_done < 0) first_done = k; else second_done = k;
      end
      if (k >= L - 3 && k <= L) begin tx_start = 1'b1; tx_data_in = d1; end
      else tx_start = 1'b0;
      @(negedge Bclk);
    end
    total++; if (done_cnt != 2) begin bad++; $display("FAIL b2b_done_cnt got=%0d exp=2", done_cnt); end
    total++;
    if (second_done - first_done != L + 1) begin
      bad++; $display("FAIL b2b_done_gap got=%0d exp=%0d", second_done - first_done, L + 1);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    logic exp_tx;
    int L, done_cnt;
    d = 8'h55; L = frame_cycles(1); done_cnt = 0;
    tx_data_in = d; tx_start = 1'b1;
    @(negedge Bclk);
    tx_start = 1'b0;
    repeat (6 * OS + 3) @(negedge Bclk);
    #2 reset = 1'b1;
    #1;
    total++; if (tx !== 1'b1)      begin bad++; $display("FAIL midreset_tx got=%b exp=1", tx); end
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b exp=0", tx_busy); end
    @(negedge Bclk);
    @(negedge Bclk);
    reset = 1'b0;
    for (int k = 0; k < 2 * OS; k++) begin
      if (tx_done === 1'b1) done_cnt++;
      @(negedge Bclk);
    end
    total++; if (done_cnt != 0) begin bad++; $display("FAIL midreset_done got=%0d exp=0", done_cnt); end
    total++; if (tx !== 1'b1)   begin bad++; $display("FAIL midreset_idle_tx got=%b exp=1", tx); end
    d = 8'h0F;
    tx_data_in = d; tx_start = 1'b1;
    @(negedge Bclk);
    tx_start = 1'b0;
    for (int k = 0; k < L + 2; k++) begin
      exp_tx = (k < L) ? model_bit(d, k / OS) : 1'b1;
      total++;
      if (tx !== exp_tx || tx_done !== (k == L)) begin
        bad++; $display("FAIL postreset k=%0d got tx/done=%b%b exp=%b%b", k, tx, tx_done, exp_tx, (k == L));
      end
      @(negedge Bclk);
    end
  endtask

  task automatic test_stop_bits();
    logic [7:0] d, rx;
    logic exp_tx;
    int L, busy_cnt, done_at;
    d = 8'h07; L = frame_cycles(2); busy_cnt = 0; done_at = -1; rx = 8'h00;
    tx_data_in2 = d; tx_start2 = 1'b1;
    @(negedge Bclk);
    tx_start2 = 1'b0;
    for (int k = 0; k < L + 3; k++) begin
      exp_tx = (k < L) ? model_bit(d, k / OS) : 1'b1;
      total++;
      if (tx2 !== exp_tx) begin bad++; $display("FAIL stop2_tx k=%0d got=%b exp=%b", k, tx2, exp_tx); end
      if (tx_busy2 === 1'b1) busy_cnt++;
      if (tx_done2 === 1'b1) done_at = k;
      // receiver-style mid-bit sampling of the data bits
      if (k % OS == OS / 2 && k / OS >= 1 && k / OS <= 8) rx[k / OS - 1] = tx2;
      if (P == 1 && k == 9 * OS + OS / 2) begin
        total++; if (tx2 !== 1'b1) begin bad++; $display("FAIL stop2_parity got=%b exp=1", tx2); end
      end
      @(negedge Bclk);
    end
    total++; if (busy_cnt != L) begin bad++; $display("FAIL stop2_busy_len got=%0d exp=%0d", busy_cnt, L); end
    total++; if (done_at != L)  begin bad++; $display("FAIL stop2_done_at got=%0d exp=%0d", done_at, L); end
    total++; if (rx !== d)      begin bad++; $display("FAIL stop2_loopback got=%h exp=%h", rx, d); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_random_frames();
    test_ignored_request();
    test_back_to_back();
    test_reset_mid_frame();
    test_stop_bits();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
